// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param: control/data inputs driven by the master,
// registered count, event pulse, sticky flags and boundary indicators returned by the slave.
interface updown_counter_param_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
);
    logic [WIDTH-1:0]  data_in;
    logic              load;
    logic              enable;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              sat_mode;
    logic              clr_flags;
    logic [WIDTH-1:0]  data_out;
    logic              wrap;
    logic              ovf;
    logic              unf;
    logic              at_max;
    logic              at_zero;

    modport master (
        output data_in, load, enable, up_down, step, limit, sat_mode, clr_flags,
        input  data_out, wrap, ovf, unf, at_max, at_zero
    );

    modport slave (
        input  data_in, load, enable, up_down, step, limit, sat_mode, clr_flags,
        output data_out, wrap, ovf, unf, at_max, at_zero
    );
endinterface

// File: rtl/updown_counter_param.sv
// Bounded up/down counter over 0..limit with variable step, wrap or saturate at the
// boundary, a one-cycle event pulse and sticky overflow/underflow flags.
module updown_counter_param #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic clk,
    input  logic reset,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_step_ext;
    logic [WIDTH-1:0] w_es;
    logic [WIDTH:0]   w_lim_p1;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_up_wrap;
    logic [WIDTH:0]   w_dn_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    // All boundary arithmetic is done one bit wider so limit+1 never overflows.
    always_comb begin
        w_step_ext = '0;
        w_step_ext[STEP_W-1:0] = bus.step;
        w_es      = (w_step_ext > bus.limit) ? bus.limit : w_step_ext;
        w_lim_p1  = {1'b0, bus.limit} + ONE_EXT;
        w_sum     = {1'b0, r_count} + {1'b0, w_es};
        w_up_wrap = w_sum - w_lim_p1;
        w_dn_wrap = {1'b0, r_count} + w_lim_p1 - {1'b0, w_es};
        w_next    = r_count;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        if (bus.load) begin
            w_next = (bus.data_in > bus.limit) ? bus.limit : bus.data_in;
        end else if (bus.enable) begin
            if (r_count > bus.limit) begin
                w_next = bus.limit;
            end else if (bus.up_down) begin
                if (w_sum <= {1'b0, bus.limit}) begin
                    w_next = w_sum[WIDTH-1:0];
                end else begin
                    w_ovf_evt = 1'b1;
                    w_next    = bus.sat_mode ? bus.limit : w_up_wrap[WIDTH-1:0];
                end
            end else begin
                if (w_es <= r_count) begin
                    w_next = r_count - w_es;
                end else begin
                    w_unf_evt = 1'b1;
                    w_next    = bus.sat_mode ? '0 : w_dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_ovf_evt | w_unf_evt;
            // A new event outranks a clear requested in the same cycle.
            r_ovf   <= w_ovf_evt | (r_ovf & ~bus.clr_flags);
            r_unf   <= w_unf_evt | (r_unf & ~bus.clr_flags);
        end
    end

    assign bus.data_out = r_count;
    assign bus.wrap     = r_wrap;
    assign bus.ovf      = r_ovf;
    assign bus.unf      = r_unf;
    assign bus.at_max   = (r_count == bus.limit);
    assign bus.at_zero  = (r_count == '0);
endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter: the next generation of the team's 16-bit load/enable up/down counter. Adds programmable width, a variable step, a runtime upper limit (modulo boundary), selectable wrap or saturate behaviour, a one-cycle boundary-event pulse and sticky overflow/underflow flags. Used wherever datapath and control logic need a bounded event, address or credit counter.

## Interface
- WIDTH, 16, counter, data_in, data_out and limit width (≥2)
- STEP_W, 4, step input width (1..WIDTH)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; when 0 at a rising edge, all state is cleared
- data_in  in  WIDTH  load value
- load  in  1  load data_in on the next edge
- enable  in  1  count by step on the next edge
- up_down  in  1  1 = count up, 0 = count down
- step  in  STEP_W  unsigned increment/decrement amount
- limit  in  WIDTH  inclusive upper bound; legal range is 0..limit
- sat_mode  in  1  1 = saturate at the boundary, 0 = wrap modulo (limit+1)
- clr_flags  in  1  clear the ovf and unf flags
- data_out  out  WIDTH  registered count
- wrap  out  1  registered one-cycle pulse on any overflow/underflow event
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag
- at_max  out  1  combinational: data_out == limit
- at_zero  out  1  combinational: data_out == 0

## Operation
- Priority per edge: reset > load > enable. No change when load = 0 and enable = 0; wrap is 0 on such cycles.
- Load: data_out <= min(data_in, limit). Load does not modify ovf or unf. wrap = 0.
- Effective step: es = min(step, limit), zero-extended to WIDTH. With step = 0 the count holds and no event occurs.
- Out-of-range recovery: if data_out > limit on an enable cycle (limit lowered after a load), data_out <= limit. No flags, wrap = 0.
- Up (up_down = 1): s = data_out + es, computed at WIDTH+1 bits.
  - If s ≤ limit: data_out <= s.
  - Else, event: wrap mode gives data_out <= s − (limit+1). Saturate mode gives data_out <= limit. In both modes ovf <= 1 and wrap <= 1.
- Down (up_down = 0):
  - If es ≤ data_out: data_out <= data_out − es.
  - Else, event: wrap mode gives data_out <= data_out + (limit+1) − es, computed at WIDTH+1 bits. Saturate mode gives data_out <= 0. In both modes unf <= 1 and wrap <= 1.
- Saturate mode at the boundary: an enabled step that would cross the boundary is still an event, so wrap pulses and the flag sets again on every such cycle.
- limit + 1 requires WIDTH+1 bits. With limit = all-ones, wrap is plain modulo 2^WIDTH.
- clr_flags clears ovf and unf on the next edge. A new event in the same cycle wins, so the corresponding flag reads 1.
- No internal FSM beyond the count register, the flags and the wrap register. Direction and mode are sampled per cycle and may change every cycle.

## Timing
- Reset values: data_out = 0, wrap = 0, ovf = 0, unf = 0. at_max and at_zero follow from the reset values and the limit input.
- Latency: one cycle from load or enable to data_out, wrap and the flags.
- wrap is high for exactly the cycle after the event edge and is not stretched. Back-to-back events give a continuously high wrap.
- Reset asserted mid-count clears all state on that edge, regardless of load, enable or clr_flags.
- at_max and at_zero are combinational from the registered data_out and the limit input. They are valid in the same cycle that limit changes.

## Test plan
- Reset: reset = 0 for 2 cycles with load = 1 and data_in = 0x1234 → data_out = 0, wrap = ovf = unf = 0. Release reset: the next load gives 0x1234 (limit = 0xFFFF).
- Up wrap: limit = 9, load 7, step = 3, up, sat_mode = 0, enable for 2 cycles → data_out goes 0 then 3. wrap is high for one cycle only; ovf stays 1.
- Down saturate: limit = 100, load 2, step = 5, down, sat_mode = 1, enable for 2 cycles → data_out goes 0 then 0. wrap is high for both cycles; unf = 1; at_zero = 1.
- Full-range down wrap: limit = 0xFFFF, load 1, step = 3, down, sat_mode = 0 → data_out = 0xFFFE, unf = 1.
- Priority: load = 1 and enable = 1 with data_in = 5 → data_out = 5. clr_flags in the same cycle as a new overflow → ovf = 1. clr_flags alone → ovf = unf = 0 on the next cycle.
- Clamping:
  - limit = 20, load 50 → data_out = 20, at_max = 1.
  - limit = 9, count 5, step = 15, up, wrap → es = 9, data_out = 4, ovf = 1.
  - Load 20 with limit = 0xFFFF, then limit = 10 and enable → data_out = 10, no flags.
